// File: rtl/conv3x3_seq_ctrl_if.sv
// Handshake/stream bundle between the stream front end, line buffer, MAC tree and conv3x3_seq_ctrl.
// master = environment side (front end + MAC tree), slave = the sequencer.
interface conv3x3_seq_ctrl_if #(
  parameter int CW = 10
);
  logic          start;
  logic          k_valid;
  logic [7:0]    k_data;
  logic          k_ready;
  logic [71:0]   kernel_flat;
  logic          pix_valid;
  logic          pix_ready;
  logic          lb_shift;
  logic          mac_go;
  logic          mac_done;
  logic          res_valid;
  logic          res_last;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, k_valid, k_data, pix_valid, mac_done,
    input  k_ready, kernel_flat, pix_ready, lb_shift, mac_go,
           res_valid, res_last, col, row, busy, done, err
  );

  modport slave (
    input  start, k_valid, k_data, pix_valid, mac_done,
    output k_ready, kernel_flat, pix_ready, lb_shift, mac_go,
           res_valid, res_last, col, row, busy, done, err
  );
endinterface

// File: rtl/conv3x3_seq_ctrl.sv
// Sequencer for the 3x3 MAC tree and line buffer: kernel load, raster pixel intake, window firing, result tagging.
// Define CONV_STRIDE2_EN to fire only windows whose origin has even column and row.
module conv3x3_seq_ctrl #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int CW      = 10,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  conv3x3_seq_ctrl_if.slave  bus
);
  localparam int OW = $clog2(MAX_OUT + 1);
`ifdef CONV_STRIDE2_EN
  localparam int N_RES = ((IMG_W - 1) / 2) * ((IMG_H - 1) / 2);
`else
  localparam int N_RES = (IMG_W - 2) * (IMG_H - 2);
`endif
  localparam int RW = $clog2(N_RES + 1);
  localparam logic [OW:0] MAX_OUT_W = (OW + 1)'(MAX_OUT);

  typedef enum logic [2:0] {IDLE, LOAD_K, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [3:0]    k_idx;
  logic [71:0]   kernel_q;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] out_next;
  logic [RW-1:0] res_cnt;
  logic          k_ready_q;
  logic          pix_ready_q;
  logic          mac_go_q;
  logic          res_valid_q;
  logic          res_last_q;
  logic          done_q;
  logic          err_q;
  logic          accept;
  logic          win;
  logic          done_ok;
  logic          col_end;
  logic          last_pix;

  always_comb begin
    accept   = bus.pix_valid && pix_ready_q;
    col_end  = (col == CW'(IMG_W - 1));
    last_pix = col_end && (row == CW'(IMG_H - 1));
    win      = accept && (col >= CW'(2)) && (row >= CW'(2));
`ifdef CONV_STRIDE2_EN
    win      = win && !col[0] && !row[0];
`endif
    done_ok  = bus.mac_done && (outstanding != '0);
    out_next = outstanding + OW'(mac_go_q) - OW'(done_ok);
  end

  // pix_ready also counts the window accepted this cycle whose mac_go is still pending,
  // so the in-flight count can never exceed MAX_OUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      k_idx       <= '0;
      kernel_q    <= '0;
      col         <= '0;
      row         <= '0;
      outstanding <= '0;
      res_cnt     <= '0;
      k_ready_q   <= 1'b0;
      pix_ready_q <= 1'b0;
      mac_go_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mac_go_q    <= win;
      outstanding <= out_next;
      res_valid_q <= done_ok;
      res_last_q  <= done_ok && (res_cnt == RW'(N_RES - 1));
      if (done_ok)
        res_cnt <= res_cnt + RW'(1);
      if (bus.mac_done && (outstanding == '0))
        err_q <= 1'b1;
      done_q      <= 1'b0;
      pix_ready_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= LOAD_K;
            k_idx     <= '0;
            k_ready_q <= 1'b1;
            res_cnt   <= '0;
          end
        end
        LOAD_K: begin
          if (bus.k_valid) begin
            kernel_q[{k_idx, 3'b000} +: 8] <= bus.k_data;
            k_idx <= k_idx + 4'd1;
            if (k_idx == 4'd8) begin
              state       <= RUN;
              k_ready_q   <= 1'b0;
              col         <= '0;
              row         <= '0;
              pix_ready_q <= ({1'b0, out_next} < MAX_OUT_W);
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (last_pix) begin
              state <= DRAIN;
              col   <= '0;
              row   <= '0;
            end else if (col_end) begin
              col <= '0;
              row <= row + CW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
          pix_ready_q <= !(accept && last_pix) &&
                         (({1'b0, out_next} + (OW + 1)'(win)) < MAX_OUT_W);
        end
        DRAIN: begin
          if ((outstanding == '0) && (res_cnt == RW'(N_RES))) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.k_ready     = k_ready_q;
  assign bus.kernel_flat = kernel_q;
  assign bus.pix_ready   = pix_ready_q;
  assign bus.lb_shift    = accept;
  assign bus.mac_go      = mac_go_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_last    = res_last_q;
  assign bus.col         = col;
  assign bus.row         = row;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_conv3x3_seq_ctrl.sv
// Self-checking bench for conv3x3_seq_ctrl on a 5x5 frame with MAX_OUT=2; scoreboard of expected results.
// Build with CONV_STRIDE2_EN defined to check the stride-2 window selection.
module tb_conv3x3_seq_ctrl;
  localparam int IMG_W   = 5;
  localparam int IMG_H   = 5;
  localparam int CW      = 4;
  localparam int MAX_OUT = 2;
`ifdef CONV_STRIDE2_EN
  localparam int N_EXP = ((IMG_W - 1) / 2) * ((IMG_H - 1) / 2);
`else
  localparam int N_EXP = (IMG_W - 2) * (IMG_H - 2);
`endif

  typedef struct {
    int due;
    bit last;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  conv3x3_seq_ctrl_if #(.CW(CW)) bus ();

  conv3x3_seq_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;
  int cycle = 0;

  // Bench model state
  int   m_col, m_row, accepted, inflight, res_idx;
  int   go_cnt, res_seen, last_cnt, done_cnt;
  bit   go_pending, exp_err;
  res_t sb[$];

  // MAC tree model state
  int   mac_delay = 1;
  int   pend[$];
  bit   spurious_req = 1'b0;

  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic bit is_window(input int c, input int r);
    bit w;
    w = (c >= 2) && (r >= 2);
`ifdef CONV_STRIDE2_EN
    w = w && (c % 2 == 0) && (r % 2 == 0);
`endif
    return w;
  endfunction

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // MAC tree: answers each mac_go with mac_done mac_delay cycles later
  initial begin
    bus.mac_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        pend.delete();
        bus.mac_done = 1'b0;
        spurious_req = 1'b0;
      end else begin
        foreach (pend[i]) pend[i]--;
        bus.mac_done = 1'b0;
        if (pend.size() > 0 && pend[0] <= 0) begin
          void'(pend.pop_front());
          bus.mac_done = 1'b1;
        end
        if (spurious_req) begin
          bus.mac_done = 1'b1;
          spurious_req = 1'b0;
        end
        if (bus.mac_go) pend.push_back(mac_delay);
      end
    end
  end

  // Monitor: window firing, coordinates, backpressure and result scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.mac_go || go_pending)
        checkOutput("mac_go", 72'(bus.mac_go), 72'(go_pending));
      if (bus.mac_go) go_cnt++;
      go_pending = 1'b0;

      if (inflight == MAX_OUT)
        checkOutput("bp_ready", 72'(bus.pix_ready), 72'(0));
      if (inflight > MAX_OUT)
        checkOutput("inflight_ovf", 72'(inflight), 72'(MAX_OUT));

      if (bus.lb_shift) begin
        checkOutput("col", 72'(bus.col), 72'(m_col));
        checkOutput("row", 72'(bus.row), 72'(m_row));
        go_pending = is_window(m_col, m_row);
        accepted++;
        if (m_col == IMG_W - 1) begin
          m_col = 0;
          m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end

      if (sb.size() > 0 && sb[0].due < cycle) begin
        checkOutput("res_missing", 72'(0), 72'(1));
        void'(sb.pop_front());
      end
      if (bus.res_valid) begin
        if (sb.size() == 0) begin
          checkOutput("res_extra", 72'(1), 72'(0));
        end else begin
          res_t e;
          e = sb.pop_front();
          checkOutput("res_cycle", 72'(cycle), 72'(e.due));
          checkOutput("res_last", 72'(bus.res_last), 72'(e.last));
        end
        res_seen++;
        if (bus.res_last) last_cnt++;
      end else if (bus.res_last) begin
        checkOutput("res_last_stray", 72'(1), 72'(0));
      end

      if (bus.mac_done) begin
        if (inflight == 0) begin
          exp_err = 1'b1;
        end else begin
          res_idx++;
          sb.push_back('{due: cycle + 1, last: (res_idx == N_EXP)});
          inflight--;
        end
      end
      if (bus.mac_go) inflight++;
      if (bus.done) done_cnt++;
    end
  end

  task automatic clear_model();
    m_col = 0; m_row = 0; accepted = 0; inflight = 0; res_idx = 0;
    go_cnt = 0; res_seen = 0; last_cnt = 0;
    go_pending = 1'b0;
    sb.delete();
  endtask

  task automatic check_reset_values();
    checkOutput("rst_kernel", bus.kernel_flat, 72'(0));
    checkOutput("rst_col", 72'(bus.col), 72'(0));
    checkOutput("rst_row", 72'(bus.row), 72'(0));
    checkOutput("rst_k_ready", 72'(bus.k_ready), 72'(0));
    checkOutput("rst_pix_ready", 72'(bus.pix_ready), 72'(0));
    checkOutput("rst_mac_go", 72'(bus.mac_go), 72'(0));
    checkOutput("rst_res_valid", 72'(bus.res_valid), 72'(0));
    checkOutput("rst_res_last", 72'(bus.res_last), 72'(0));
    checkOutput("rst_done", 72'(bus.done), 72'(0));
    checkOutput("rst_err", 72'(bus.err), 72'(0));
    checkOutput("rst_busy", 72'(bus.busy), 72'(0));
  endtask

  // Called aligned to posedge+1
  task automatic start_frame();
    clear_model();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("k_ready_on", 72'(bus.k_ready), 72'(1));
  endtask

  task automatic load_weights(input logic [71:0] kexp);
    for (int i = 0; i < 9; i++) begin
      bus.k_valid = 1'b1;
      bus.k_data  = kexp[8*i +: 8];
      @(posedge clk); #1;
      bus.k_valid = 1'b0;
      if (i % 3 == 1) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    checkOutput("kernel_flat", bus.kernel_flat, kexp);
    checkOutput("k_ready_off", 72'(bus.k_ready), 72'(0));
    checkOutput("busy_run", 72'(bus.busy), 72'(1));
    checkOutput("pix_ready_run", 72'(bus.pix_ready), 72'(1));
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input int target, input bit gappy);
    int guard = 0;
    while (accepted < target && guard < 3000) begin
      bus.pix_valid = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    bus.pix_valid = 1'b0;
    if (accepted < target)
      checkOutput("pix_timeout", 72'(accepted), 72'(target));
  endtask

  task automatic finish_frame();
    int d0 = done_cnt;
    int guard = 0;
    while (done_cnt == d0 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    @(negedge clk);
    checkOutput("done_once", 72'(done_cnt - d0), 72'(1));
    checkOutput("busy_idle", 72'(bus.busy), 72'(0));
    checkOutput("go_count", 72'(go_cnt), 72'(N_EXP));
    checkOutput("res_count", 72'(res_seen), 72'(N_EXP));
    checkOutput("last_count", 72'(last_cnt), 72'(1));
    checkOutput("sb_empty", 72'(sb.size()), 72'(0));
    checkOutput("err_frame", 72'(bus.err), 72'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    bus.start = 1'b0; bus.k_valid = 1'b0; bus.k_data = '0; bus.pix_valid = 1'b0;
    exp_err = 1'b0; done_cnt = 0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 1: weights 1..9, back-to-back pixels, 1-cycle MAC
    mac_delay = 1;
    start_frame();
    load_weights(72'h09_08_07_06_05_04_03_02_01);
    applyStimulus(IMG_W * IMG_H, 1'b0);
    finish_frame();

    // Frame 2: reversed weights, gappy pixels, slow MAC forces backpressure
    mac_delay = 6;
    start_frame();
    load_weights(72'h01_02_03_04_05_06_07_08_09);
    applyStimulus(IMG_W * IMG_H, 1'b1);
    finish_frame();

    // Spurious mac_done during kernel load
    mac_delay = 2;
    start_frame();
    spurious_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("err_set", 72'(bus.err), 72'(1));
    checkOutput("err_k_ready", 72'(bus.k_ready), 72'(1));
    load_weights(72'h5a_4b_3c_2d_1e_0f_a0_b1_c2);
    applyStimulus(IMG_W * IMG_H, 1'b0);
    finish_frame();
    checkOutput("err_sticky", 72'(bus.err), 72'(1));

    // Reset in the middle of a frame
    mac_delay = 3;
    start_frame();
    load_weights(72'h11_22_33_44_55_66_77_88_99);
    applyStimulus(12, 1'b0);
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    checkOutput("no_done_on_abort", 72'(done_cnt - d0), 72'(0));
    exp_err = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean frame after the abort
    start_frame();
    load_weights(72'h09_08_07_06_05_04_03_02_01);
    applyStimulus(IMG_W * IMG_H, 1'b1);
    finish_frame();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
